// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction memory port, decoder handshake, redirect and status.
// master = fetch unit side, slave = memory/decoder/execute side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 19,
  parameter int CNT_W   = 16
);
  logic               start;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  modport master (
    input  start, imem_instr, out_ready, redirect_valid, redirect_target,
    output imem_addr, out_valid, out_instr, out_pc, halted, fetch_count
  );

  modport slave (
    output start, imem_instr, out_ready, redirect_valid, redirect_target,
    input  imem_addr, out_valid, out_instr, out_pc, halted, fetch_count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC sequencer with 2-entry prefetch buffer; first instruction valid 2 cycles after start.
// A full buffer with no pop stalls the PC; redirects flush the buffer and restart at the target.
module instr_fetch_unit #(
  parameter int ADDR_W   = 12,
  parameter int INSTR_W  = 19,
  parameter int RESET_PC = 1,
  parameter int CNT_W    = 16
) (
  input logic             clk,
  input logic             rst,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  entry_t             fifo0_q, fifo0_d;
  entry_t             fifo1_q, fifo1_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]   fc_q, fc_d;
  logic               halted_q, halted_d;

  logic               pop_req;
  logic               pop;
  logic               push;
  logic               flush;
  logic [1:0]         cnt_mid;
  entry_t             new_entry;

  assign pop_req   = (cnt_q != 2'd0) && bus.out_ready;
  assign new_entry = '{pc: pc_q, instr: bus.imem_instr};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fc_d    = fc_q;
    pop     = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = START_PC;
          fc_d    = '0;
          flush   = 1'b1;
        end
      end
      RUN: begin
        if (bus.redirect_valid) begin
          pc_d  = bus.redirect_target;
          flush = 1'b1;
        end else begin
          pop = pop_req;
          if (cnt_q != 2'd2 || pop_req) begin
            if (bus.imem_instr != '0) begin
              push = 1'b1;
              pc_d = pc_q + ADDR_W'(1);
              fc_d = (fc_q == '1) ? fc_q : fc_q + CNT_W'(1);
            end else begin
              state_d = HALT;
            end
          end
        end
      end
      HALT: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = START_PC;
          fc_d    = '0;
          flush   = 1'b1;
        end else if (bus.redirect_valid) begin
          state_d = RUN;
          pc_d    = bus.redirect_target;
          flush   = 1'b1;
        end else begin
          pop = pop_req;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Head is always slot 0: a pop shifts slot 1 down, a push fills the first free slot.
  always_comb begin
    fifo0_d = fifo0_q;
    fifo1_d = fifo1_q;
    cnt_mid = cnt_q;
    cnt_d   = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      if (pop) begin
        fifo0_d = fifo1_q;
        cnt_mid = cnt_q - 2'd1;
      end
      if (push) begin
        if (cnt_mid == 2'd0) fifo0_d = new_entry;
        else                 fifo1_d = new_entry;
      end
      cnt_d = cnt_mid + {1'b0, push};
    end
    halted_d = (state_d == HALT) && (cnt_d == 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= START_PC;
      fifo0_q  <= '0;
      fifo1_q  <= '0;
      cnt_q    <= 2'd0;
      fc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fifo0_q  <= fifo0_d;
      fifo1_q  <= fifo1_d;
      cnt_q    <= cnt_d;
      fc_q     <= fc_d;
      halted_q <= halted_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.out_valid   = (cnt_q != 2'd0);
  assign bus.out_instr   = fifo0_q.instr;
  assign bus.out_pc      = fifo0_q.pc;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = fc_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench: expected deliveries are the program walk from each start/redirect target.
module tb_instr_fetch_unit;
  localparam int AW = 12;
  localparam int IW = 19;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW), .CNT_W(CW)) bus ();

  instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(1), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [IW-1:0] mem [4096];
  assign bus.imem_instr = mem[bus.imem_addr];

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference: from pc p the decoder sees mem[p], mem[p+1], ... up to the first zero word.
  function automatic int load_walk(input logic [AW-1:0] from);
    logic [AW-1:0] p;
    int n;
    sb.delete();
    p = from;
    n = 0;
    while (n < 4096 && mem[p] != '0) begin
      sb.push_back('{pc: p, instr: mem[p]});
      p = p + 1'b1;
      n++;
    end
    return n;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(output int len);
    bus.start = 1'b1;
    len = load_walk(AW'(1));
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_redirect(input logic [AW-1:0] tgt);
    int len;
    bus.out_ready       = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = tgt;
    len = load_walk(tgt);
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget, output int n);
    n = 0;
    while (!bus.halted && n < budget) begin
      tick();
      n++;
    end
    check(name, bus.halted, 1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got pc %0d, want no delivery", bus.out_pc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", bus.out_pc, e.pc);
        check("sb_instr", bus.out_instr, e.instr);
      end
    end
  end

  initial begin
    int len, n;
    logic no_redir;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    for (int a = 0; a < 4096; a++) mem[a] = '0;

    #2;
    check("rst_valid", bus.out_valid, 0);
    check("rst_addr", bus.imem_addr, 1);
    check("rst_pc", bus.out_pc, 0);
    check("rst_instr", bus.out_instr, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_count", bus.fetch_count, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    // straight-line program
    for (int a = 1; a <= 5; a++) mem[a] = IW'($urandom_range(1, 19'h7FFFF));
    mem[6] = '0;
    bus.out_ready = 1'b1;
    do_start(len);
    check("lat_v0", bus.out_valid, 0);
    tick();
    check("lat_v1", bus.out_valid, 1);
    check("lat_pc1", bus.out_pc, 1);
    wait_halt("line_halt", 50, n);
    check("line_cycles", n, 5);
    check("line_count", bus.fetch_count, 5);
    check("line_sb_empty", sb.size(), 0);

    // backpressure
    bus.out_ready = 1'b0;
    do_start(len);
    tick(5);
    check("bp_valid", bus.out_valid, 1);
    check("bp_head", bus.out_pc, 1);
    check("bp_addr", bus.imem_addr, 3);
    check("bp_count", bus.fetch_count, 2);
    bus.out_ready = 1'b1;
    wait_halt("bp_halt", 50, n);
    check("bp_sb_empty", sb.size(), 0);
    check("bp_count_end", bus.fetch_count, 5);

    // redirect while buffer holds pc 4,5
    for (int a = 6; a <= 10; a++) mem[a] = IW'($urandom_range(1, 19'h7FFFF));
    mem[11] = '0;
    for (int a = 17; a <= 19; a++) mem[a] = IW'($urandom_range(1, 19'h7FFFF));
    mem[20] = '0;
    bus.out_ready = 1'b1;
    do_start(len);
    n = 0;
    while (!(bus.out_valid && bus.out_pc == 3) && n < 30) begin
      tick();
      n++;
    end
    check("rd_reach3", bus.out_pc, 3);
    tick();
    bus.out_ready = 1'b0;
    tick(2);
    check("rd_head4", bus.out_pc, 4);
    check("rd_addr6", bus.imem_addr, 6);
    do_redirect(AW'(17));
    check("rd_flush", bus.out_valid, 0);
    check("rd_addr17", bus.imem_addr, 17);
    tick();
    check("rd_valid", bus.out_valid, 1);
    check("rd_pc17", bus.out_pc, 17);
    bus.out_ready = 1'b1;
    wait_halt("rd_halt", 50, n);
    check("rd_sb_empty", sb.size(), 0);
    check("rd_count", bus.fetch_count, 8);

    // branch onto an end word
    do_redirect(AW'(20));
    check("bh_halted0", bus.halted, 0);
    check("bh_valid", bus.out_valid, 0);
    tick();
    check("bh_halted1", bus.halted, 1);
    check("bh_count", bus.fetch_count, 8);
    check("bh_addr", bus.imem_addr, 20);

    // pc wrap and counter saturation
    force dut.fc_q = 16'hFFFD;
    tick();
    release dut.fc_q;
    tick();
    check("sat_preload", bus.fetch_count, 16'hFFFD);
    mem[4095] = IW'($urandom_range(1, 19'h7FFFF));
    mem[0]    = IW'($urandom_range(1, 19'h7FFFF));
    do_redirect(AW'(4095));
    bus.out_ready = 1'b1;
    wait_halt("wrap_halt", 50, n);
    check("wrap_sb_empty", sb.size(), 0);
    check("sat_count", bus.fetch_count, 16'hFFFF);
    mem[0] = '0;

    // asynchronous reset with a full buffer
    bus.out_ready = 1'b0;
    do_start(len);
    tick(4);
    check("ar_full_addr", bus.imem_addr, 3);
    #3;
    rst = 1'b1;
    #1;
    check("ar_valid", bus.out_valid, 0);
    check("ar_addr", bus.imem_addr, 1);
    check("ar_count", bus.fetch_count, 0);
    check("ar_halted", bus.halted, 0);
    sb.delete();
    #2;
    rst = 1'b0;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_target = AW'(50);
    tick();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick(4);
    check("idle_valid", bus.out_valid, 0);
    check("idle_addr", bus.imem_addr, 1);
    check("idle_count", bus.fetch_count, 0);

    // randomized programs, handshakes and redirects
    for (int seg = 0; seg < 6; seg++) begin
      mem[0] = '0;
      for (int a = 1; a < 4096; a++)
        mem[a] = ($urandom % 12 == 0) ? '0 : IW'($urandom_range(1, 19'h7FFFF));
      no_redir = (seg < 2);
      bus.out_ready = ($urandom % 4 != 0);
      do_start(len);
      for (int c = 0; c < 150; c++) begin
        if (!no_redir && $urandom % 20 == 0) begin
          do_redirect(AW'($urandom_range(1, 4095)));
        end else begin
          bus.out_ready = ($urandom % 4 != 0);
          tick();
        end
      end
      bus.out_ready = 1'b1;
      wait_halt("rand_halt", 6000, n);
      check("rand_sb_empty", sb.size(), 0);
      if (no_redir) check("rand_count", bus.fetch_count, len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
